// File: rtl/mp_bus_pkg.sv
// Shared bus package for the matrix processor.
// Holds the unit-select nibbles driven on address[15:12], the instruction
// opcode values, the decoded instruction layout and the fetch FSM states.
package mp_bus_pkg;

    // Unit-select nibbles placed on address[15:12]
    localparam logic [3:0] MainMemEn   = 4'd0;
    localparam logic [3:0] RegFileEn   = 4'd1;
    localparam logic [3:0] InstrMemEn  = 4'd2;
    localparam logic [3:0] MatrixAluEn = 4'd3;
    localparam logic [3:0] ExecUnitEn  = 4'd4;
    localparam logic [3:0] IntAlu      = 4'd5;

    // Opcodes
    localparam logic [7:0] Stop       = 8'hFF;
    localparam logic [7:0] MMult      = 8'h00;
    localparam logic [7:0] Madd       = 8'h01;
    localparam logic [7:0] Msub       = 8'h02;
    localparam logic [7:0] Mtranspose = 8'h03;
    localparam logic [7:0] MScale     = 8'h04;
    localparam logic [7:0] MScaleImm  = 8'h05;
    localparam logic [7:0] IntAdd     = 8'h10;
    localparam logic [7:0] IntSub     = 8'h11;
    localparam logic [7:0] IntMult    = 8'h12;
    localparam logic [7:0] IntDiv     = 8'h13;

    // Instruction word bits [31:0]
    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] dest;
        logic [7:0] src1;
        logic [7:0] src2;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_HALT,
        S_ERROR
    } fetch_state_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction splitter.
// Ports:
//   word      in  32  instruction bits [31:0] of the fetched ROM word
//   instr     out     opcode/dest/src1/src2 fields
//   is_stop   out  1  opcode equals STOP_OPCODE
//   is_int_op out  1  opcode[7:4] == 4'h1 (integer ALU operation)
module instr_decode
    import mp_bus_pkg::*;
#(
    parameter logic [7:0] STOP_OPCODE = Stop
) (
    input  logic [31:0] word,
    output instr_t      instr,
    output logic        is_stop,
    output logic        is_int_op
);

    assign instr     = instr_t'(word);
    assign is_stop   = (word[31:24] == STOP_OPCODE);
    assign is_int_op = (word[31:28] == 4'h1);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: bus initiator for the instruction ROM.
// Fetches one 256-bit word per request, keeps bits [31:0], decodes them and
// offers the instruction to the execute unit over valid/ready. Halts on the
// Stop opcode; running past MAX_PC without a Stop raises error.
// Ports:
//   Clk, nReset        clock, synchronous active-low reset
//   start              begin fetching from pc 0 (honoured in IDLE/HALT/ERROR)
//   address, nRead     bus address {INSTR_MEM_EN, 0, pc} and read strobe
//   InstructDataIn     ROM word
//   instr_valid/ready  handshake to the execute unit
//   opcode..src2       decoded fields, is_int_op integer-op flag
//   pc                 index of the held or requested instruction
//   busy, halted, error status
module instr_fetch_unit
    import mp_bus_pkg::*;
#(
    parameter logic [3:0]  INSTR_MEM_EN = 4'd2,
    parameter int unsigned PC_WIDTH     = 4,
    parameter int unsigned MAX_PC       = 9,
    parameter int unsigned DATA_WIDTH   = 256,
    parameter logic [7:0]  STOP_OPCODE  = 8'hFF
) (
    input  logic                  Clk,
    input  logic                  nReset,
    input  logic                  start,
    output logic [15:0]           address,
    output logic                  nRead,
    input  logic [DATA_WIDTH-1:0] InstructDataIn,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [7:0]            opcode,
    output logic [7:0]            dest,
    output logic [7:0]            src1,
    output logic [7:0]            src2,
    output logic                  is_int_op,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  busy,
    output logic                  halted,
    output logic                  error
);

    fetch_state_t        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         addr_q, addr_d;
    logic                nread_q, nread_d;
    logic                valid_q, valid_d;
    instr_t              instr_q, instr_d;
    logic                int_q, int_d;
    logic                busy_q, busy_d;
    logic                halted_q, halted_d;
    logic                error_q, error_d;

    instr_t              dec_instr;
    logic                dec_stop;
    logic                dec_int;
    logic                unused_hi;

    assign unused_hi = ^InstructDataIn[DATA_WIDTH-1:32];

    instr_decode #(
        .STOP_OPCODE (STOP_OPCODE)
    ) u_decode (
        .word      (InstructDataIn[31:0]),
        .instr     (dec_instr),
        .is_stop   (dec_stop),
        .is_int_op (dec_int)
    );

    // Every output is a register; the comb block computes its next value.
    // nRead defaults high, so it is low only for the REQ cycle of each fetch
    // (the ROM captures the word on REQ's closing edge).
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        nread_d  = 1'b1;
        valid_d  = valid_q;
        instr_d  = instr_q;
        int_d    = int_q;
        halted_d = halted_q;
        error_d  = error_q;

        case (state_q)
            S_IDLE, S_HALT, S_ERROR: begin
                if (start) begin
                    state_d  = S_REQ;
                    pc_d     = '0;
                    addr_d   = {INSTR_MEM_EN, 12'h000};
                    nread_d  = 1'b0;
                    halted_d = 1'b0;
                    error_d  = 1'b0;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                addr_d = '0;
                if (dec_stop) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = S_ISSUE;
                    valid_d = 1'b1;
                    instr_d = dec_instr;
                    int_d   = dec_int;
                end
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
                    if (pc_q == PC_WIDTH'(MAX_PC)) begin
                        state_d  = S_ERROR;
                        error_d  = 1'b1;
                        halted_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        pc_d    = pc_q + PC_WIDTH'(1);
                        addr_d  = {INSTR_MEM_EN, 12'(pc_q + PC_WIDTH'(1))};
                        nread_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_ISSUE);
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            addr_q   <= '0;
            nread_q  <= 1'b1;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            int_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            nread_q  <= nread_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            int_q    <= int_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            error_q  <= error_d;
        end
    end

    assign address     = addr_q;
    assign nRead       = nread_q;
    assign instr_valid = valid_q;
    assign opcode      = instr_q.opcode;
    assign dest        = instr_q.dest;
    assign src1        = instr_q.src1;
    assign src2        = instr_q.src2;
    assign is_int_op   = int_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign error       = error_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int MAX_PC = 9;

    logic         Clk = 1'b0;
    logic         nReset = 1'b0;
    logic         start = 1'b0;
    logic         instr_ready = 1'b0;
    logic [255:0] InstructDataIn;
    logic [15:0]  address;
    logic         nRead;
    logic         instr_valid;
    logic [7:0]   opcode, dest, src1, src2;
    logic         is_int_op;
    logic [3:0]   pc;
    logic         busy, halted, error;

    int checks = 0;
    int passes = 0;

    instr_fetch_unit #(
        .INSTR_MEM_EN (4'd2),
        .PC_WIDTH     (4),
        .MAX_PC       (MAX_PC),
        .DATA_WIDTH   (256),
        .STOP_OPCODE  (8'hFF)
    ) dut (
        .Clk            (Clk),
        .nReset         (nReset),
        .start          (start),
        .address        (address),
        .nRead          (nRead),
        .InstructDataIn (InstructDataIn),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .opcode         (opcode),
        .dest           (dest),
        .src1           (src1),
        .src2           (src2),
        .is_int_op      (is_int_op),
        .pc             (pc),
        .busy           (busy),
        .halted         (halted),
        .error          (error)
    );

    always #5 Clk = ~Clk;

    // ROM: captures the addressed word on an edge where nRead is low
    logic [31:0] rom [16];
    logic [31:0] rom_q = 32'h0;
    assign InstructDataIn = {{7{32'hDEADBEEF}}, rom_q};
    always @(posedge Clk) if (nRead === 1'b0) rom_q <= rom[address[3:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Transaction-level expectation model: a fetch of index k launched at an
    // edge shows nRead low with address 0x2000+k for one cycle, and two edges
    // after launch either presents rom[k] or halts on a Stop.
    logic [15:0] exp_addr   = 16'h0;
    logic        exp_nread  = 1'b1;
    logic        exp_valid  = 1'b0;
    logic [31:0] exp_word   = 32'h0;
    int          exp_pc     = 0;
    logic        exp_busy   = 1'b0;
    logic        exp_halted = 1'b0;
    logic        exp_error  = 1'b0;
    int          age        = -1;

    task automatic launch(input int k);
        exp_pc    = k;
        exp_addr  = 16'h2000 + 16'(k);
        exp_nread = 1'b0;
        exp_busy  = 1'b1;
        age       = 0;
    endtask

    always @(posedge Clk) begin
        if (!nReset) begin
            exp_addr = 16'h0; exp_nread = 1'b1; exp_valid = 1'b0; exp_pc = 0;
            exp_busy = 1'b0; exp_halted = 1'b0; exp_error = 1'b0; age = -1;
        end else if (age == 0) begin
            exp_nread = 1'b1;
            age = 1;
        end else if (age == 1) begin
            exp_addr = 16'h0;
            age = -1;
            if (rom[exp_pc][31:24] == 8'hFF) begin
                exp_halted = 1'b1;
                exp_busy   = 1'b0;
            end else begin
                exp_valid = 1'b1;
                exp_word  = rom[exp_pc];
            end
        end else if (exp_valid && instr_ready) begin
            exp_valid = 1'b0;
            if (exp_pc == MAX_PC) begin
                exp_error = 1'b1; exp_halted = 1'b1; exp_busy = 1'b0;
            end else begin
                launch(exp_pc + 1);
            end
        end else if (!exp_busy && start) begin
            exp_halted = 1'b0;
            exp_error  = 1'b0;
            launch(0);
        end
    end

    // Handshakes actually completed by the DUT (pre-edge values)
    int issued = 0;
    always @(posedge Clk) if (nReset && instr_valid === 1'b1 && instr_ready) issued++;

    bit cmp_en = 0;
    bit seen_ff = 0;
    bit saw_200a = 0;
    logic prev_nread = 1'b1;

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("address", 32'(address), 32'(exp_addr));
            chk("nRead", 32'(nRead), 32'(exp_nread));
            chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
            chk("pc", 32'(pc), 32'(exp_pc));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("halted", 32'(halted), 32'(exp_halted));
            chk("error", 32'(error), 32'(exp_error));
            if (exp_valid) begin
                chk("fields", {opcode, dest, src1, src2}, exp_word);
                chk("is_int_op", 32'(is_int_op), 32'(exp_word[31:28] == 4'h1));
            end
            if (nRead === 1'b0) begin
                chk("nread_one_cycle", 32'(prev_nread), 32'd1);
                chk("nread_vs_valid", 32'(instr_valid), 32'd0);
            end
            if (instr_valid === 1'b1 && opcode == 8'hFF) seen_ff = 1;
            if (address == 16'h200A) saw_200a = 1;
            prev_nread = nRead;
        end
    end

    task automatic sample();
        @(negedge Clk);
        #1;
    endtask

    task automatic wait_halted(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (halted === 1'b1) break;
            sample();
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    int base;

    initial begin
        rom[0] = 32'h01_02_00_01; rom[1] = 32'h10_10_09_08;
        rom[2] = 32'h00_03_01_02; rom[3] = 32'h11_04_03_02;
        rom[4] = 32'h02_05_01_01; rom[5] = 32'h12_06_05_04;
        rom[6] = 32'h03_07_06_00; rom[7] = 32'h13_08_07_06;
        rom[8] = 32'h04_09_08_00; rom[9] = 32'hFF_00_00_00;
        for (int i = 10; i < 16; i++) rom[i] = 32'h05_0A_00_00;

        // Reset state
        repeat (3) sample();
        chk("rst_addr", 32'(address), 32'h0);
        chk("rst_nread", 32'(nRead), 32'd1);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_fields", {opcode, dest, src1, src2}, 32'h0);
        chk("rst_flags", {28'h0, is_int_op, busy, halted, error}, 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        nReset = 1'b1;
        cmp_en = 1;
        sample();

        // First fetch and its latency
        start = 1'b1;
        sample();
        start = 1'b0;
        chk("e0_addr", 32'(address), 32'h2000);
        chk("e0_nread", 32'(nRead), 32'd0);
        sample();
        chk("e1_nread", 32'(nRead), 32'd1);
        chk("e1_valid", 32'(instr_valid), 32'd0);
        sample();
        chk("e2_valid", 32'(instr_valid), 32'd1);
        chk("e2_fields", {opcode, dest, src1, src2}, 32'h01_02_00_01);
        chk("e2_pc", 32'(pc), 32'd0);
        instr_ready = 1'b1;
        sample();
        chk("i1_addr", 32'(address), 32'h2001);
        instr_ready = 1'b0;
        start = 1'b1;          // ignored while busy
        sample();
        start = 1'b0;
        sample();

        // Stall on instruction 1
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_fields", {opcode, dest, src1, src2}, 32'h10_10_09_08);
            chk("stall_int", 32'(is_int_op), 32'd1);
            chk("stall_nread", 32'(nRead), 32'd1);
            sample();
        end
        instr_ready = 1'b1;
        sample();
        chk("i2_addr", 32'(address), 32'h2002);
        chk("i2_nread", 32'(nRead), 32'd0);

        // Run to Stop with ready held high
        wait_halted(100);
        chk("issued_9", 32'(issued), 32'd9);
        chk("no_ff_issued", 32'(seen_ff), 32'd0);
        chk("stop_error", 32'(error), 32'd0);
        chk("stop_pc", 32'(pc), 32'd9);

        // Restart from HALT, then reset during WAIT
        start = 1'b1;
        sample();
        start = 1'b0;
        chk("rs_halted", 32'(halted), 32'd0);
        chk("rs_addr", 32'(address), 32'h2000);
        sample();
        nReset = 1'b0;
        sample();
        chk("wr_nread", 32'(nRead), 32'd1);
        chk("wr_addr", 32'(address), 32'h0);
        chk("wr_valid", 32'(instr_valid), 32'd0);
        chk("wr_busy", 32'(busy), 32'd0);
        nReset = 1'b1;
        start = 1'b1;
        sample();
        start = 1'b0;
        chk("wr_refetch", 32'(address), 32'h2000);
        chk("wr_refetch_nread", 32'(nRead), 32'd0);
        wait_halted(100);

        // No Stop: overrun past MAX_PC
        rom[9] = 32'h01_02_00_01;
        base = issued;
        start = 1'b1;
        sample();
        start = 1'b0;
        wait_halted(100);
        chk("ovr_error", 32'(error), 32'd1);
        chk("ovr_issued", 32'(issued - base), 32'd10);
        chk("no_200a", 32'(saw_200a), 32'd0);

        // Restart from ERROR
        start = 1'b1;
        sample();
        start = 1'b0;
        chk("re_error", 32'(error), 32'd0);
        chk("re_halted", 32'(halted), 32'd0);
        chk("re_addr", 32'(address), 32'h2000);
        repeat (4) sample();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Bus initiator for the instruction memory ROM.
- Drives the generic 16-bit address bus and nRead to fetch 256-bit instruction words, one per request.
- Extracts instruction bits [31:0] and splits them into opcode/dest/src1/src2.
- Presents each decoded instruction to the execute unit over a valid/ready handshake, and halts on the Stop opcode (FFh).

Parameters:
- INSTR_MEM_EN, 4'd2, unit-select nibble driven on address[15:12]
- PC_WIDTH, 4, program counter width; PC drives address[PC_WIDTH-1:0]
- MAX_PC, 9, highest valid instruction index
- DATA_WIDTH, 256, width of the instruction bus word
- STOP_OPCODE, 8'hFF, opcode that terminates the program

Ports:
- Clk  in  1  system clock, all state updates on posedge
- nReset  in  1  synchronous active-low reset
- start  in  1  begin fetching (accepted in IDLE, HALT or ERROR)
- address  out  16  bus address {INSTR_MEM_EN, 8'h00, pc}
- nRead  out  1  active-low read strobe to instruction memory
- InstructDataIn  in  DATA_WIDTH  instruction word returned by the ROM
- instr_valid  out  1  decoded instruction fields valid
- instr_ready  in  1  execute unit accepts the instruction
- opcode, dest, src1, src2  out  8 each  instruction fields [31:24], [23:16], [15:8], [7:0]
- is_int_op  out  1  opcode[7:4]==4'h1 (integer ALU op)
- pc  out  PC_WIDTH  index of the instruction currently held or requested
- busy  out  1  state is REQ, WAIT or ISSUE
- halted  out  1  Stop fetched, or error
- error  out  1  PC ran past MAX_PC without a Stop

Behaviour:
- Reset: nReset low at a posedge forces the following on the next edge, regardless of state (including mid-fetch):
  - state=IDLE, pc=0, address=16'h0000, nRead=1
  - instr_valid=0, all fields 0, is_int_op=0
  - halted=0, error=0, busy=0
- All outputs are registered.
- States: IDLE, REQ, WAIT, ISSUE, HALT, ERROR.
- IDLE: outputs quiescent. If start=1 at an edge: go to REQ, address<={INSTR_MEM_EN,8'h00,pc}, nRead<=0.
- REQ (1 cycle): address and nRead=0 are stable; the ROM latches its output at the closing edge. Go to WAIT.
- WAIT (1 cycle): at the closing edge:
  - sample InstructDataIn[31:0]; nRead<=1; address<=16'h0000
  - if opcode==STOP_OPCODE: go to HALT, halted<=1; Stop is never presented (instr_valid stays 0)
  - else: load fields and is_int_op, instr_valid<=1, go to ISSUE
- ISSUE:
  - While instr_ready=0, hold instr_valid and all fields stable; no bus activity.
  - On an edge with instr_ready=1:
    - instr_valid<=0
    - if pc==MAX_PC: go to ERROR, error<=1, halted<=1
    - else: pc<=pc+1, go to REQ with the new address and nRead=0
- Latency:
  - start sampled at edge E0 → nRead low after E0 → ROM output after E1 → instr_valid high after E2.
  - Back-to-back throughput: one instruction per 3 cycles with instr_ready held high.
- HALT/ERROR: bus idle (nRead=1). start=1 restarts: clears halted/error, sets pc=0, goes to REQ.
- start is ignored while busy.
- instr_ready is ignored when instr_valid=0.
- nRead is low for exactly one cycle per fetch and never while instr_valid=1.
- pc never wraps; overrun is reported via ERROR.

Decomposition:
- Shared package mp_bus_pkg:
  - unit-enable constants MainMemEn..IntAlu (0..5)
  - opcode constants: Stop FFh, MMult 00h, Madd 01h, Msub 02h, Mtranspose 03h, MScale 04h, MScaleImm 05h, IntAdd 10h, IntSub 11h, IntMult 12h, IntDiv 13h
  - packed struct instr_t {opcode, dest, src1, src2}
- One sub-module, instr_decode (combinational): 32-bit word → instr_t, is_stop, is_int_op.

Test Plan:
- Reset, pulse start, ROM model loaded with the default program:
  - address=16'h2000 with nRead=0 for exactly one cycle
  - instr_valid rises 2 edges after start with opcode=01, dest=02, src1=00, src2=01, pc=0
- Hold instr_ready low 5 cycles on instruction 1 (32'h10_10_09_08):
  - fields stable, is_int_op=1, nRead stays 1
  - on instr_ready=1, the next fetch uses address=16'h2002
- instr_ready tied high for the full run:
  - 9 instructions issued, pc 0..8, one per 3 cycles
  - Stop (32'hFF_00_00_00) fetched at index 9 → halted=1, instr_valid never seen with opcode FF, error=0
- Assert nReset during WAIT:
  - next edge: nRead=1, address=0, instr_valid=0, busy=0
  - a subsequent start fetches 16'h2000 again
- ROM word 9 replaced with 32'h01_02_00_01 (no Stop), MAX_PC=9:
  - after index 9 is accepted, error=1, halted=1
  - address 16'h200A is never driven
- start pulsed while busy → ignored, fetch sequence unchanged.
- start in HALT → halted clears and address=16'h2000 is driven next cycle.
